// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding MIPS instruction fetch with redirect handling
// and a one-entry valid/ready output buffer toward decode.
module fetch_unit #(
  parameter int AW = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC = 32'h0000_0040
) (
  input  logic          clka,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          redir_valid,
  input  logic [1:0]    redir_sel,
  input  logic [AW-1:0] redir_pc4,
  input  logic [15:0]   redir_imm,
  input  logic [25:0]   redir_index,
  input  logic [AW-1:0] redir_reg,
  output logic          misalign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_pc4
);
  typedef enum logic {S_REQ, S_WAIT} state_t;
  state_t state, state_d;
  logic kill, kill_d, fire, load;
  logic [AW-1:0] pc, pc_d, in_pc, target;
  assign imem_req = rst_n && state == S_REQ && (!out_valid || out_ready);
  assign imem_addr = pc;
  always_comb
    target = redir_sel == 2'd0 ? redir_pc4 + {{(AW-18){redir_imm[15]}}, redir_imm, 2'b00}
           : redir_sel == 2'd1 ? {redir_pc4[AW-1:28], redir_index, 2'b00}
           : redir_sel == 2'd2 ? {redir_reg[AW-1:2], 2'b00}
           : {EXC_VEC[AW-1:2], 2'b00};
  // A redirect never lets a response reach the buffer; kill covers the one still in flight.
  always_comb begin
    fire = imem_req && imem_gnt;
    load = state == S_WAIT && imem_rvalid && !kill && !redir_valid;
    pc_d = redir_valid ? target : fire ? pc + AW'(4) : pc;
    state_d = state == S_REQ ? (fire ? S_WAIT : S_REQ) : (imem_rvalid ? S_REQ : S_WAIT);
    kill_d = state == S_REQ ? fire && redir_valid : !imem_rvalid && (kill || redir_valid);
  end
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      state <= S_REQ;
      kill <= 1'b0;
      pc <= RESET_PC[AW-1:0];
      in_pc <= '0;
      misalign <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc <= '0;
      out_pc4 <= '0;
    end else begin
      state <= state_d;
      kill <= kill_d;
      pc <= pc_d;
      if (fire) in_pc <= pc;
      misalign <= redir_valid && redir_sel == 2'd2 && |redir_reg[1:0];
      out_valid <= !redir_valid && (load || (out_valid && !out_ready));
      if (load) begin
        out_instr <= imem_rdata;
        out_pc <= in_pc;
        out_pc4 <= in_pc + AW'(4);
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus against a transaction-level fetch model plus literal pins.
module tb_fetch_unit;
  logic clka = 0, rst_n = 0;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic redir_valid = 0;
  logic [1:0] redir_sel = 0;
  logic [31:0] redir_pc4 = 0, redir_reg = 0;
  logic [15:0] redir_imm = 0;
  logic [25:0] redir_index = 0;
  logic misalign, out_valid, out_ready = 1;
  logic [31:0] out_instr, out_pc, out_pc4;
  int checks = 0, errors = 0;
  int lat = 1;
  logic gnt_en = 1;
  logic mem_pend = 0;
  int mem_wait = 0;
  logic [31:0] mem_addr = 0;
  logic last_fire = 0;
  logic [31:0] q_addr[$], q_out[$];
  logic m_busy, m_kill, m_valid, m_mis;
  logic [31:0] m_pc, m_inpc, m_instr, m_opc;

  fetch_unit dut (
    .clka(clka), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_sel(redir_sel), .redir_pc4(redir_pc4),
    .redir_imm(redir_imm), .redir_index(redir_index), .redir_reg(redir_reg),
    .misalign(misalign), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4)
  );

  always #5 clka = ~clka;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] target();
    case (redir_sel)
      2'd0: return redir_pc4 + 32'(int'($signed(redir_imm)) * 4);
      2'd1: return (redir_pc4 & 32'hF000_0000) | (32'(redir_index) * 4);
      2'd2: return redir_reg - (redir_reg % 4);
      default: return 32'h40;
    endcase
  endfunction

  function automatic logic [31:0] nth(logic [31:0] q[$], int i);
    return q.size() > i ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_kill = 0; m_valid = 0; m_mis = 0;
    m_pc = 0; m_inpc = 0; m_instr = 0; m_opc = 0;
    mem_pend = 0; mem_wait = 0;
  endtask

  task automatic cyc();
    logic m_req, d_fire, tk;
    logic [31:0] tgt, d_addr;
    imem_gnt = gnt_en;
    imem_rvalid = mem_pend && mem_wait == 1;
    imem_rdata = imem_rvalid ? mem_word(mem_addr) : 32'h0;
    #1;
    m_req = !m_busy && (!m_valid || out_ready);
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", out_valid, m_valid);
    chk("misalign", misalign, m_mis);
    if (m_valid) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_pc", out_pc, m_opc);
      chk("out_pc4", out_pc4, m_opc + 4);
    end
    d_fire = imem_req && imem_gnt;
    d_addr = imem_addr;
    if (d_fire) q_addr.push_back(imem_addr);
    if (out_valid && out_ready) q_out.push_back(out_pc);
    last_fire = d_fire;
    @(posedge clka);
    tgt = target();
    tk = m_busy && imem_rvalid && !m_kill && !redir_valid;
    if (tk) begin m_instr = imem_rdata; m_opc = m_inpc; end
    m_valid = !redir_valid && (tk || (m_valid && !out_ready));
    m_mis = redir_valid && redir_sel == 2 && redir_reg % 4 != 0;
    if (m_busy && imem_rvalid) begin m_busy = 0; m_kill = 0; end
    else if (m_busy && redir_valid) m_kill = 1;
    if (m_req && imem_gnt) begin m_busy = 1; m_kill = redir_valid; m_inpc = m_pc; m_pc = m_pc + 4; end
    if (redir_valid) m_pc = tgt;
    if (imem_rvalid) mem_pend = 0;
    else if (mem_pend) mem_wait--;
    if (d_fire) begin mem_pend = 1; mem_wait = lat; mem_addr = d_addr; end
    @(negedge clka);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic until_grant();
    int n = 0;
    do begin cyc(); n++; end while (!last_fire && n < 20);
    if (!last_fire) chk("grant_timeout", last_fire, 1);
  endtask

  task automatic redirect(logic [1:0] sel, logic [31:0] pc4, logic [15:0] imm, logic [25:0] idx, logic [31:0] rg);
    redir_valid = 1; redir_sel = sel; redir_pc4 = pc4; redir_imm = imm; redir_index = idx; redir_reg = rg;
    cyc();
    redir_valid = 0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clka);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_pc4", out_pc4, 0);
    chk("rst_misalign", misalign, 0);
    @(negedge clka);
    rst_n = 1;
    run(8);
    chk("seq_addr0", nth(q_addr, 0), 32'h0);
    chk("seq_addr1", nth(q_addr, 1), 32'h4);
    chk("seq_addr2", nth(q_addr, 2), 32'h8);
    chk("seq_out0", nth(q_out, 0), 32'h0);
    chk("seq_out1", nth(q_out, 1), 32'h4);
    out_ready = 0;
    run(5);
    chk("stall_valid", out_valid, 1);
    chk("stall_req", imem_req, 0);
    out_ready = 1;
    #1 chk("resume_req", imem_req, 1);
    run(4);
    lat = 3;
    until_grant();
    q_addr.delete(); q_out.delete();
    redirect(2'd0, 32'h100, 16'hFFFC, 0, 0);
    lat = 1;
    run(10);
    chk("br_addr", nth(q_addr, 0), 32'hF0);
    chk("br_out", nth(q_out, 0), 32'hF0);
    gnt_en = 0;
    redirect(2'd1, 32'hA000_0010, 0, 26'h0000040, 0);
    gnt_en = 1;
    q_addr.delete(); q_out.delete();
    run(6);
    chk("j_addr", nth(q_addr, 0), 32'hA000_0100);
    redirect(2'd2, 0, 0, 0, 32'h0000_2003);
    chk("jr_misalign_hi", misalign, 1);
    q_addr.delete(); q_out.delete();
    cyc();
    chk("jr_misalign_lo", misalign, 0);
    run(6);
    chk("jr_addr", nth(q_addr, 0), 32'h2000);
    gnt_en = 0;
    run(3);
    gnt_en = 1;
    redirect(2'd3, 0, 0, 0, 0);
    q_addr.delete(); q_out.delete();
    run(8);
    chk("exc_addr", nth(q_addr, 0), 32'h40);
    chk("exc_out", nth(q_out, 0), 32'h40);
    lat = 3;
    until_grant();
    redirect(2'd0, 32'h300, 16'h0004, 0, 0);
    redirect(2'd1, 32'h1000_0000, 0, 26'h0000100, 0);
    q_addr.delete(); q_out.delete();
    lat = 1;
    run(8);
    chk("b2b_addr", nth(q_addr, 0), 32'h1000_0400);
    lat = 3;
    until_grant();
    rst_n = 0;
    #1;
    chk("midrst_req", imem_req, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_addr", imem_addr, 0);
    m_reset();
    @(negedge clka);
    rst_n = 1;
    lat = 1;
    q_addr.delete(); q_out.delete();
    run(6);
    chk("post_rst_addr", nth(q_addr, 0), 32'h0);
    chk("post_rst_out", nth(q_out, 0), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the MIPS core.
- Holds the program counter and issues one outstanding request at a time to instruction memory over a req/gnt/rvalid handshake.
- Buffers each returned instruction in a one-entry output register with a valid/ready handshake toward decode.
- Computes redirect targets internally (branch, jump, jr, exception) and discards in-flight responses on redirect.

Parameters:
- AW, 32, PC/address width; legal range 29..32.
- RESET_PC, 32'h0000_0000, PC loaded on reset (low AW bits used).
- EXC_VEC, 32'h0000_0040, exception redirect target (low AW bits used).

Ports:
- clka  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request.
- imem_addr  output  AW  fetch address; word aligned; equals pc.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid; exactly one per granted request, at least 1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- redir_valid  input  1  redirect pulse from decode/execute.
- redir_sel  input  2  0 branch, 1 jump, 2 jr, 3 exception.
- redir_pc4  input  AW  PC+4 of the redirecting instruction.
- redir_imm  input  16  branch offset (words).
- redir_index  input  26  jump instr_index.
- redir_reg  input  AW  jr register value.
- misalign  output  1  one-cycle pulse: jr target had nonzero [1:0].
- out_valid  output  1  instruction buffer holds an instruction.
- out_ready  input  1  decode accepts the instruction.
- out_instr  output  32  buffered instruction.
- out_pc  output  AW  address of out_instr.
- out_pc4  output  AW  out_pc + 4.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, state=S_REQ, kill=0.
  - out_valid=0, out_instr=0, out_pc=0, out_pc4=0, misalign=0.
  - imem_req is forced to 0 while rst_n=0.
- Redirect targets, all arithmetic mod 2^AW:
  - branch: redir_pc4 + (sext(redir_imm) << 2).
  - jump: {redir_pc4[AW-1:28], redir_index, 2'b00}.
  - jr: {redir_reg[AW-1:2], 2'b00}; misalign=1 the next cycle if redir_reg[1:0] != 0.
  - exception: EXC_VEC with [1:0] forced to 0.
- S_REQ:
  - imem_req = !out_valid | out_ready.
  - On imem_req & imem_gnt: in_pc <= pc, pc <= pc + 4, go to S_WAIT.
- S_WAIT:
  - imem_req = 0.
  - On imem_rvalid with kill=1: drop the data, clear kill, go to S_REQ.
  - On imem_rvalid with kill=0: load out_instr=imem_rdata, out_pc=in_pc, out_pc4=in_pc+4; out_valid=1; go to S_REQ.
- Output handshake:
  - out_valid & out_ready clears out_valid next cycle, unless a load happens in the same cycle (load wins).
  - Output fields are held stable while out_valid & !out_ready.
- Redirect (redir_valid=1) has highest priority in every state:
  - pc <= target; out_valid <= 0 the next cycle. An accept in the same cycle is still honoured by decode.
  - In S_REQ with gnt in the same cycle: the grant stands, kill <= 1, go to S_WAIT, pc <= target (not target+4).
  - In S_WAIT without rvalid: kill <= 1, stay in S_WAIT.
  - In S_WAIT with rvalid in the same cycle: the response is discarded, kill stays 0, go to S_REQ.
  - Back-to-back redirects: the last one wins; kill stays 1 until the single outstanding response returns.
- Latency and throughput:
  - With gnt in the request cycle and rvalid the next cycle, out_valid rises 2 cycles after the request cycle.
  - Peak throughput is 1 instruction per 2 cycles.
- Never more than one outstanding request; imem_addr is stable while imem_req & !imem_gnt.
- Reset mid-operation abandons the outstanding request. The memory must drop its response on reset, and no rvalid is honoured until a new grant.

Test Plan:
- Reset release, memory gnt immediate and rvalid +1, out_ready=1 → imem_addr sequence 0x0, 0x4, 0x8; out_pc 0x0 then 0x4, out_pc4 0x4 then 0x8; out_valid high every other cycle.
- out_ready=0 for 5 cycles with an instruction buffered → out_instr/out_pc stable; imem_req=0 throughout; fetch resumes the cycle out_ready rises.
- Branch redirect with redir_pc4=0x100 and redir_imm=16'hFFFC while S_WAIT → in-flight response dropped; next imem_addr=0xF0; out_valid=0 until the 0xF0 instruction returns.
- Jump with redir_pc4=0xA000_0010, redir_index=26'h0000040 → next imem_addr=0xA000_0100.
- jr with redir_reg=0x0000_2003 → misalign pulses 1 cycle; next imem_addr=0x2000.
- Exception redirect in the same cycle as gnt, then rvalid → response discarded; next imem_addr=0x40; rst_n asserted mid-S_WAIT → imem_req=0, out_valid=0, imem_addr=RESET_PC immediately.
